// File: rtl/audio_sample_scheduler.sv
// Buffers bursty receiver samples in a FIFO and releases one per fixed sample tick,
// sequenced by an IDLE/PREFILL/PLAY machine. Define SCHED_FLOW_CTRL_EN for hysteretic rts_n.
module audio_sample_scheduler #(
    parameter int CLK_PER_SAMPLE = 612,
    parameter int AW             = 6,
    parameter int PREFILL        = 32,
    parameter int HIGH_WATER     = 56,
    parameter int LOW_WATER      = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic signed [15:0] in_sample,
    input  logic               in_valid,
    output logic signed [15:0] out_sample,
    output logic               out_strobe,
    output logic               playing,
    output logic [AW:0]        level,
    output logic               overflow,
    output logic [7:0]         underrun_cnt,
    output logic               rts_n
);

    localparam int            CW          = $clog2(CLK_PER_SAMPLE);
    localparam logic [CW-1:0] TICK_AT     = CW'(CLK_PER_SAMPLE - 1);
    localparam logic [AW:0]   PREFILL_LVL = (AW+1)'(PREFILL);

    if (CLK_PER_SAMPLE < 4 || PREFILL < 1 || PREFILL > (1 << AW) || LOW_WATER >= HIGH_WATER) begin : g_param_check
        $error("audio_sample_scheduler: illegal parameter combination");
    end

    typedef enum logic [1:0] {S_IDLE, S_PREFILL, S_PLAY} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [AW:0]        wr_ptr, rd_ptr;
    logic signed [15:0] mem [2**AW];

    logic        tick_p0, empty_p0, full_p0, pop_p0, push_p0, drop_p0;
    logic        underrun_p0, flush_p0;
    logic [AW:0] wr_nxt_p0, rd_nxt_p0;

    // Stage p0: tick, FIFO status and push/pop decisions for this cycle
    always_comb begin
        tick_p0     = (cnt == TICK_AT);
        empty_p0    = (wr_ptr == rd_ptr);
        full_p0     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        pop_p0      = tick_p0 && (state == S_PLAY) && !empty_p0;
        underrun_p0 = tick_p0 && (state == S_PLAY) && empty_p0;
        // A same-cycle pop frees the slot, so a push into a full FIFO is still accepted.
        push_p0     = in_valid && (state != S_IDLE) && (!full_p0 || pop_p0);
        drop_p0     = in_valid && (state != S_IDLE) && full_p0 && !pop_p0;
        flush_p0    = !enable || (state == S_IDLE);
        wr_nxt_p0   = wr_ptr + {{AW{1'b0}}, push_p0};
        rd_nxt_p0   = rd_ptr + {{AW{1'b0}}, pop_p0};
        if (flush_p0) begin
            wr_nxt_p0 = wr_ptr;
            rd_nxt_p0 = wr_ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (push_p0) mem[wr_ptr[AW-1:0]] <= in_sample;
    end

    // Stage p1: registered pointers, level, output sample and control state
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            out_sample   <= '0;
            out_strobe   <= 1'b0;
            playing      <= 1'b0;
            overflow     <= 1'b0;
            underrun_cnt <= '0;
            rts_n        <= 1'b0;
        end else begin
            cnt        <= tick_p0 ? '0 : cnt + 1'b1;
            wr_ptr     <= wr_nxt_p0;
            rd_ptr     <= rd_nxt_p0;
            level      <= wr_nxt_p0 - rd_nxt_p0;
            out_strobe <= tick_p0;
            if (tick_p0) out_sample <= pop_p0 ? mem[rd_ptr[AW-1:0]] : 16'sd0;
            if (drop_p0) overflow <= 1'b1;
            if (underrun_p0 && underrun_cnt != 8'hFF) underrun_cnt <= underrun_cnt + 8'd1;

            if (!enable) begin
                state   <= S_IDLE;
                playing <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        state   <= S_PREFILL;
                        playing <= 1'b0;
                    end
                    S_PREFILL: begin
                        if (level >= PREFILL_LVL) begin
                            state   <= S_PLAY;
                            playing <= 1'b1;
                        end
                    end
                    S_PLAY: begin
                        if (underrun_p0) begin
                            state   <= S_PREFILL;
                            playing <= 1'b0;
                        end
                    end
                    default: begin
                        state   <= S_IDLE;
                        playing <= 1'b0;
                    end
                endcase
            end

`ifdef SCHED_FLOW_CTRL_EN
            if (state == S_IDLE)
                rts_n <= 1'b0;
            else if (level >= (AW+1)'(HIGH_WATER))
                rts_n <= 1'b1;
            else if (level <= (AW+1)'(LOW_WATER))
                rts_n <= 1'b0;
`else
            rts_n <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_audio_sample_scheduler.sv
// Scoreboard bench for audio_sample_scheduler: stimulus queues expected strobe samples,
// a monitor pops and compares on every out_strobe; status outputs are checked inline.
module tb_audio_sample_scheduler;

    localparam int CPS = 8;
    localparam int AW  = 3;
`ifdef SCHED_FLOW_CTRL_EN
    localparam logic FLOW = 1'b1;
`else
    localparam logic FLOW = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst, enable, in_valid;
    logic signed [15:0] in_sample, out_sample;
    logic               out_strobe, playing, overflow, rts_n;
    logic [AW:0]        level;
    logic [7:0]         underrun_cnt;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];

    audio_sample_scheduler #(
        .CLK_PER_SAMPLE(CPS), .AW(AW), .PREFILL(4), .HIGH_WATER(6), .LOW_WATER(2)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .in_sample(in_sample), .in_valid(in_valid),
        .out_sample(out_sample), .out_strobe(out_strobe), .playing(playing), .level(level),
        .overflow(overflow), .underrun_cnt(underrun_cnt), .rts_n(rts_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_strobes(input int n);
        for (int i = 0; i < n; i++) begin
            int c;
            c = 0;
            do begin
                @(negedge clk);
                c++;
            end while (!out_strobe && c < 3 * CPS);
            check("strobe_arrived", {31'b0, out_strobe}, 32'd1);
        end
    endtask

    task automatic check_reset();
        check("rst_out_sample", {16'b0, out_sample}, 32'd0);
        check("rst_out_strobe", {31'b0, out_strobe}, 32'd0);
        check("rst_playing", {31'b0, playing}, 32'd0);
        check("rst_level", {28'b0, level}, 32'd0);
        check("rst_overflow", {31'b0, overflow}, 32'd0);
        check("rst_underrun_cnt", {24'b0, underrun_cnt}, 32'd0);
        check("rst_rts_n", {31'b0, rts_n}, 32'd0);
    endtask

    // Monitor: every strobe must have a queued expectation
    initial begin
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (out_strobe) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL strobe_unexpected: sample 0x%0h with no expectation queued", out_sample);
                end else begin
                    e = exp_q.pop_front();
                    check("strobe_sample", {16'b0, out_sample}, {16'b0, e});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; enable = 1'b0; in_valid = 1'b0; in_sample = '0;
        cycles(3);
        check_reset();
        rst = 1'b0; enable = 1'b1;

        // Idle playback: zeros on each strobe
        exp_q.push_back(16'h0); exp_q.push_back(16'h0);
        wait_strobes(2);
        check("b_level", {28'b0, level}, 32'd0);
        check("b_playing", {31'b0, playing}, 32'd0);

        // Prefill with 1..4, play them, then underrun
        exp_q.push_back(16'h1); exp_q.push_back(16'h2); exp_q.push_back(16'h3);
        exp_q.push_back(16'h4); exp_q.push_back(16'h0);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_sample = 16'(i + 1);
            cycles(1);
        end
        in_valid = 1'b0;
        check("c_level4", {28'b0, level}, 32'd4);
        check("c_playing_lag", {31'b0, playing}, 32'd0);
        cycles(1);
        check("c_playing_rise", {31'b0, playing}, 32'd1);
        wait_strobes(5);
        check("c_underrun_cnt", {24'b0, underrun_cnt}, 32'd1);
        check("c_playing_fall", {31'b0, playing}, 32'd0);
        check("c_level0", {28'b0, level}, 32'd0);

        // Ten-sample burst in PREFILL: last two dropped, first eight play
        exp_q.push_back(16'h0);
        for (int i = 0; i < 8; i++) exp_q.push_back(16'(17 + i));
        exp_q.push_back(16'h0);
        cycles(4);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_sample = 16'(17 + i);
            cycles(1);
        end
        in_valid = 1'b0;
        check("d_level_full", {28'b0, level}, 32'd8);
        check("d_overflow", {31'b0, overflow}, 32'd1);
        check("d_playing", {31'b0, playing}, 32'd1);
        check("d_rts_high", {31'b0, rts_n}, {31'b0, FLOW});
        wait_strobes(6);
        check("d_level2", {28'b0, level}, 32'd2);
        check("d_rts_lag", {31'b0, rts_n}, {31'b0, FLOW});
        cycles(1);
        check("d_rts_low", {31'b0, rts_n}, 32'd0);
        wait_strobes(3);
        check("d_underrun_cnt", {24'b0, underrun_cnt}, 32'd2);
        check("d_playing_fall", {31'b0, playing}, 32'd0);

        rst = 1'b1;
        cycles(2);
        check_reset();
        rst = 1'b0;

        // Fill exactly to full, then push in the tick cycle
        exp_q.push_back(16'h0);
        wait_strobes(1);
        exp_q.push_back(16'h0);
        for (int i = 0; i < 4; i++) exp_q.push_back(16'(16'h41 + i));
        cycles(4);
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_sample = 16'(16'h41 + i);
            cycles(1);
        end
        in_valid = 1'b0;
        check("f_level_full", {28'b0, level}, 32'd8);
        check("f_playing", {31'b0, playing}, 32'd1);
        check("f_overflow_pre", {31'b0, overflow}, 32'd0);
        cycles(3);
        in_valid = 1'b1; in_sample = 16'h0050;
        cycles(1);
        in_valid = 1'b0;
        check("f_level_held", {28'b0, level}, 32'd8);
        check("f_overflow_post", {31'b0, overflow}, 32'd0);
        check("f_rts", {31'b0, rts_n}, {31'b0, FLOW});

        // Drop enable mid-PLAY with five buffered
        wait_strobes(3);
        check("g_level5", {28'b0, level}, 32'd5);
        enable = 1'b0;
        cycles(1);
        check("g_level_flushed", {28'b0, level}, 32'd0);
        check("g_playing", {31'b0, playing}, 32'd0);
        exp_q.push_back(16'h0); exp_q.push_back(16'h0);
        in_valid = 1'b1; in_sample = 16'h7777;
        cycles(1);
        in_valid = 1'b0;
        cycles(1);
        check("g_idle_push_level", {28'b0, level}, 32'd0);
        check("g_idle_push_overflow", {31'b0, overflow}, 32'd0);
        check("g_rts_idle", {31'b0, rts_n}, 32'd0);
        check("g_underrun_cnt", {24'b0, underrun_cnt}, 32'd0);
        wait_strobes(2);

        rst = 1'b1;
        cycles(2);
        check_reset();
        check("queue_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/audio_sample_scheduler.md
# audio_sample_scheduler

Rate-decouples the UART audio receiver from the audio output stage. It buffers 16-bit samples arriving in bursts at UART pace (`in_valid` pulses) in an internal FIFO. It releases them to the DAC/PWM stage on a fixed sample-rate tick derived from `clk`. A prefill/play/underrun state machine sequences playback. Optional hysteretic flow control throttles the host.

## Interface
- `CLK_PER_SAMPLE`, 612, `clk` cycles per output sample (27 MHz / 44.1 kHz); must be ≥ 4.
- `AW`, 6, FIFO address width; depth = 2^AW entries.
- `PREFILL`, 32, FIFO level required before PLAY begins; 1 ≤ PREFILL ≤ 2^AW.
- `HIGH_WATER`, 56, level at or above which `rts_n` deasserts (flow control build only).
- `LOW_WATER`, 24, level at or below which `rts_n` reasserts; LOW_WATER < HIGH_WATER.

Ports:
- `clk` in 1: system clock, 27 MHz.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: playback enable; low forces IDLE.
- `in_sample` in 16: signed sample from the receiver.
- `in_valid` in 1: one-cycle pulse; `in_sample` valid this cycle.
- `out_sample` out 16: signed sample to the output stage, registered.
- `out_strobe` out 1: one-cycle pulse per sample period; `out_sample` is new this cycle.
- `playing` out 1: high while in PLAY.
- `level` out AW+1: current FIFO occupancy, 0..2^AW.
- `overflow` out 1: sticky; a push was dropped because the FIFO was full.
- `underrun_cnt` out 8: count of underrun events, saturating at 255.
- `rts_n` out 1: host flow control; 0 = host may send.

## Operation
- FIFO: 2^AW × 16. Read/write pointers are AW+1 bits, and wrap naturally.
  - Empty when pointers are equal.
  - Full when the MSBs differ and the lower bits are equal.
  - `level` = wr_ptr − rd_ptr, registered, and always consistent with the pointers.
- Push: `in_valid` && state≠IDLE && !full.
  - Push while full: sample dropped, `overflow` ← 1. Cleared only by `rst`.
  - Push in IDLE: dropped silently; `overflow` is not set.
- Tick: a free-running counter runs 0..CLK_PER_SAMPLE−1. Tick asserts when the counter equals CLK_PER_SAMPLE−1. The counter runs in every state, so the output rate never stops.
- Every tick produces exactly one `out_strobe`, in all states.
- States:
  - IDLE: FIFO pointers held equal (flushed); ticks emit 0. Go to PREFILL when `enable`=1.
  - PREFILL: ticks emit 0. Go to PLAY when `level` ≥ PREFILL, evaluated every cycle. The first pop happens on the next tick.
  - PLAY: on each tick, if `level` > 0, pop the head to `out_sample`.
    - If `level` = 0 (underrun): emit 0, increment `underrun_cnt` (saturating), go to PREFILL.
- Any state with `enable`=0 goes to IDLE next cycle; the FIFO flushes on entry. `overflow` and `underrun_cnt` are kept.
- Simultaneous push and pop: both are performed and `level` is unchanged.
  - A pop when `level`=0 is not possible, even with a push in the same cycle. The underrun rule applies and the pushed sample is stored.
- Push while full with a pop in the same cycle: the pop frees the slot first, so the push is accepted and `overflow` is not set.

## Timing
- Reset values:
  - State IDLE; tick counter 0.
  - `out_sample`=0, `out_strobe`=0, `playing`=0, `level`=0, `overflow`=0, `underrun_cnt`=0.
  - `rts_n`=0.
- `out_strobe` and the new `out_sample` appear 1 cycle after the tick cycle, i.e. every CLK_PER_SAMPLE cycles.
- `level` updates 1 cycle after a push or pop.
- PREFILL→PLAY transition occurs 1 cycle after `level` reaches PREFILL; `playing` rises with it.
- Throughput: at most one push and one pop per cycle. The input rate is unconstrained except by FIFO capacity.
- `rst` mid-operation: all state returns to reset values next cycle; FIFO contents are discarded.

## Configuration
- `SCHED_FLOW_CTRL_EN` defined: `rts_n` is registered with hysteresis.
  - `rts_n` ← 1 when `level` ≥ HIGH_WATER.
  - `rts_n` ← 0 when `level` ≤ LOW_WATER.
  - Otherwise `rts_n` holds; it is forced to 0 in IDLE.
  - 1-cycle lag from `level`.
- Not defined: `rts_n` is tied to 0; HIGH_WATER and LOW_WATER are unused. FIFO, states and counters are unchanged.

## Test plan
Bench parameters: CLK_PER_SAMPLE=8, AW=3, PREFILL=4, HIGH_WATER=6, LOW_WATER=2.
- Reset then `enable`=1, no input → `out_strobe` every 8 cycles with `out_sample`=0; `playing`=0; `level`=0.
- Push 0x0001..0x0004 → `playing` rises 1 cycle after `level`=4. The next four strobes carry 1, 2, 3, 4 in order.
- From that state, push nothing more → fifth strobe carries 0, `underrun_cnt`=1, state PREFILL, `playing`=0.
- In PREFILL, push 10 samples back-to-back → `level` saturates at 8; `overflow`=1. Playback order is the first 8 samples. With `SCHED_FLOW_CTRL_EN`: `rts_n`=1 from `level`=6 and back to 0 once drained to 2.
- Full FIFO in PLAY; push in the tick cycle → push accepted, `level` stays 8, `overflow` stays 0.
- Drop `enable` mid-PLAY with `level`=5 → next cycle IDLE, `level`=0, strobes continue with 0. Assert `rst` → all outputs at reset values, `underrun_cnt`=0.
